// File: rtl/zap_predecode_pkg.sv
// Shared predecode definitions: sequencer state encoding, ARM block-transfer
// field positions and offset arithmetic widths.
package zap_predecode_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_WB   = 2'd2
  } seq_state_t;

  localparam int P_BIT       = 24;
  localparam int U_BIT       = 23;
  localparam int S_BIT       = 22;
  localparam int W_BIT       = 21;
  localparam int L_BIT       = 20;
  localparam int RN_LSB      = 16;
  localparam int RN_MSB      = 19;
  localparam int REGLIST_LSB = 0;
  localparam int REGLIST_MSB = 15;

  localparam int OFFSET_W   = 13;
  localparam int WORD_BYTES = 4;

  // Offset of the lowest-numbered register relative to Rn for mode {P,U}.
  function automatic logic [OFFSET_W-1:0] start_offset(input logic p, input logic u,
                                                       input logic [11:0] n4);
    logic [OFFSET_W-1:0] n;
    logic [OFFSET_W-1:0] res;
    n = {1'b0, n4};
    case ({p, u})
      2'b01:   res = '0;
      2'b11:   res = OFFSET_W'(WORD_BYTES);
      2'b00:   res = OFFSET_W'(WORD_BYTES) - n;
      default: res = -n;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ldm_stm_sequencer_if.sv
// Upstream instruction handshake plus downstream micro-op bus of the LDM/STM
// sequencer; slave is the sequencer side, master the surrounding pipeline.
interface ldm_stm_sequencer_if;
  import zap_predecode_pkg::*;

  logic                i_valid;
  logic                o_ready;
  logic [31:0]         i_instr;
  logic [11:0]         i_total_offset;
  logic                i_flush;
  logic                o_valid;
  logic                i_ready;
  logic [3:0]          o_reg;
  logic [3:0]          o_base;
  logic [OFFSET_W-1:0] o_offset;
  logic                o_load;
  logic                o_user;
  logic                o_nop;
  logic                o_wb;
  logic                o_last;

  modport slave (
    input  i_valid, i_instr, i_total_offset, i_flush, i_ready,
    output o_ready, o_valid, o_reg, o_base, o_offset, o_load, o_user, o_nop, o_wb, o_last
  );

  modport master (
    output i_valid, i_instr, i_total_offset, i_flush, i_ready,
    input  o_ready, o_valid, o_reg, o_base, o_offset, o_load, o_user, o_nop, o_wb, o_last
  );

endinterface

// File: rtl/ldm_stm_sequencer_lowest_set_bit.sv
// 16-bit priority encoder: index of the least significant set bit, plus a
// flag for an all-zero mask (index then reads 0).
module lowest_set_bit (
  input  logic [15:0] mask,
  output logic [3:0]  idx,
  output logic        zero
);

  always_comb begin
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (mask[i]) idx = 4'(i);
    end
  end

  assign zero = (mask == 16'd0);

endmodule

// File: rtl/ldm_stm_sequencer.sv
// Expands one LDM/STM into single-register micro-ops, lowest register first.
// Optional trailing base-writeback micro-op: define ZAP_LDM_STM_WRITEBACK_EN.
module ldm_stm_sequencer
  import zap_predecode_pkg::*;
(
  input logic               i_clk,
  input logic               i_reset_n,
  ldm_stm_sequencer_if.slave bus
);

  seq_state_t          state_reg, state_next;
  logic [15:0]         mask_reg, mask_next;
  logic [OFFSET_W-1:0] offset_reg, offset_next;
  logic [3:0]          rn_reg, rn_next;
  logic                load_reg, load_next;
  logic                user_reg, user_next;
  logic [3:0]          lsb_idx;
  logic                lsb_zero;
  logic                last_bit;
  logic                unused_bits;
`ifdef ZAP_LDM_STM_WRITEBACK_EN
  logic                wb_en_reg, wb_en_next;
  logic                up_reg, up_next;
  logic [11:0]         n4_reg, n4_next;
`endif

  lowest_set_bit u_lsb (
    .mask (mask_reg),
    .idx  (lsb_idx),
    .zero (lsb_zero)
  );

  // An empty mask in XFER can only mean an empty register list.
  assign last_bit    = ((mask_reg & (mask_reg - 16'd1)) == 16'd0);
  assign unused_bits = ^{bus.i_instr[31:25], bus.i_instr[W_BIT]};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg  <= ST_IDLE;
      mask_reg   <= '0;
      offset_reg <= '0;
      rn_reg     <= '0;
      load_reg   <= 1'b0;
      user_reg   <= 1'b0;
`ifdef ZAP_LDM_STM_WRITEBACK_EN
      wb_en_reg  <= 1'b0;
      up_reg     <= 1'b0;
      n4_reg     <= '0;
`endif
    end else begin
      state_reg  <= state_next;
      mask_reg   <= mask_next;
      offset_reg <= offset_next;
      rn_reg     <= rn_next;
      load_reg   <= load_next;
      user_reg   <= user_next;
`ifdef ZAP_LDM_STM_WRITEBACK_EN
      wb_en_reg  <= wb_en_next;
      up_reg     <= up_next;
      n4_reg     <= n4_next;
`endif
    end
  end

  always_comb begin
    state_next  = state_reg;
    mask_next   = mask_reg;
    offset_next = offset_reg;
    rn_next     = rn_reg;
    load_next   = load_reg;
    user_next   = user_reg;
`ifdef ZAP_LDM_STM_WRITEBACK_EN
    wb_en_next  = wb_en_reg;
    up_next     = up_reg;
    n4_next     = n4_reg;
`endif
    if (bus.i_flush) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.i_valid) begin
            state_next  = ST_XFER;
            mask_next   = bus.i_instr[REGLIST_MSB:REGLIST_LSB];
            offset_next = start_offset(bus.i_instr[P_BIT], bus.i_instr[U_BIT],
                                       bus.i_total_offset);
            rn_next     = bus.i_instr[RN_MSB:RN_LSB];
            load_next   = bus.i_instr[L_BIT];
            user_next   = bus.i_instr[S_BIT];
`ifdef ZAP_LDM_STM_WRITEBACK_EN
            wb_en_next  = bus.i_instr[W_BIT];
            up_next     = bus.i_instr[U_BIT];
            n4_next     = bus.i_total_offset;
`endif
          end
        end
        ST_XFER: begin
          if (bus.i_ready) begin
            mask_next   = mask_reg & (mask_reg - 16'd1);
            offset_next = offset_reg + OFFSET_W'(WORD_BYTES);
            if (last_bit) begin
`ifdef ZAP_LDM_STM_WRITEBACK_EN
              state_next = (wb_en_reg && !lsb_zero) ? ST_WB : ST_IDLE;
`else
              state_next = ST_IDLE;
`endif
            end
          end
        end
`ifdef ZAP_LDM_STM_WRITEBACK_EN
        ST_WB: begin
          if (bus.i_ready) state_next = ST_IDLE;
        end
`endif
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Outputs depend only on registered state, so they hold while stalled.
  always_comb begin
    bus.o_ready  = (state_reg == ST_IDLE);
    bus.o_valid  = 1'b0;
    bus.o_reg    = '0;
    bus.o_base   = '0;
    bus.o_offset = '0;
    bus.o_load   = 1'b0;
    bus.o_user   = 1'b0;
    bus.o_nop    = 1'b0;
    bus.o_wb     = 1'b0;
    bus.o_last   = 1'b0;
    case (state_reg)
      ST_XFER: begin
        bus.o_valid  = 1'b1;
        bus.o_reg    = lsb_idx;
        bus.o_base   = rn_reg;
        bus.o_offset = lsb_zero ? '0 : offset_reg;
        bus.o_load   = load_reg;
        bus.o_user   = user_reg;
        bus.o_nop    = lsb_zero;
`ifdef ZAP_LDM_STM_WRITEBACK_EN
        bus.o_last   = lsb_zero || (last_bit && !wb_en_reg);
`else
        bus.o_last   = last_bit;
`endif
      end
`ifdef ZAP_LDM_STM_WRITEBACK_EN
      ST_WB: begin
        bus.o_valid  = 1'b1;
        bus.o_reg    = rn_reg;
        bus.o_base   = rn_reg;
        bus.o_offset = up_reg ? {1'b0, n4_reg} : -{1'b0, n4_reg};
        bus.o_load   = load_reg;
        bus.o_user   = user_reg;
        bus.o_wb     = 1'b1;
        bus.o_last   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench for ldm_stm_sequencer: an address-range model of each
// block transfer feeds a per-cycle comparator, plus hand-computed literals.
module tb_ldm_stm_sequencer;

  typedef struct packed {
    logic [3:0]  rg;
    logic [3:0]  base;
    logic [12:0] off;
    logic        load;
    logic        user;
    logic        nop;
    logic        wb;
    logic        last;
  } op_t;

`ifdef ZAP_LDM_STM_WRITEBACK_EN
  localparam bit WB_BUILD = 1'b1;
`else
  localparam bit WB_BUILD = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  op_t  exp_q[$];
  op_t  obs_q[$];

  ldm_stm_sequencer_if bus ();

  ldm_stm_sequencer dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input bit p, input bit u, input bit s, input bit w,
                                     input bit l, input logic [3:0] rn, input logic [15:0] list);
    return {4'hE, 3'b100, p, u, s, w, l, rn, list};
  endfunction

  function automatic int popcnt(input logic [15:0] v);
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic op_t obs_at(input int i);
    if (i < obs_q.size()) return obs_q[i];
    return '0;
  endfunction

  // Registers occupy consecutive words from the lowest address of the block.
  task automatic push_model(input logic [31:0] ins);
    int  n, lo, k;
    bit  p, u, wb;
    op_t op;
    n  = popcnt(ins[15:0]);
    p  = ins[24];
    u  = ins[23];
    wb = WB_BUILD && ins[21] && (n > 0);
    if (u) lo = p ? 4 : 0;
    else   lo = p ? -4 * n : 4 - 4 * n;
    op      = '0;
    op.base = ins[19:16];
    op.load = ins[20];
    op.user = ins[22];
    if (n == 0) begin
      op.nop  = 1'b1;
      op.last = 1'b1;
      exp_q.push_back(op);
    end else begin
      k = 0;
      for (int i = 0; i < 16; i++) begin
        if (ins[i]) begin
          op.rg   = 4'(i);
          op.off  = 13'(lo + 4 * k);
          op.last = (k == n - 1) && !wb;
          exp_q.push_back(op);
          k++;
        end
      end
      if (wb) begin
        op.rg   = ins[19:16];
        op.off  = 13'(u ? 4 * n : -4 * n);
        op.wb   = 1'b1;
        op.last = 1'b1;
        exp_q.push_back(op);
      end
    end
  endtask

  always @(negedge clk) begin
    op_t act, cmp;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      checks++;
      if (bus.o_valid !== (exp_q.size() != 0) || bus.o_ready !== (exp_q.size() == 0)) begin
        errors++;
        $display("FAIL handshake: valid=%0b ready=%0b, required valid=%0b ready=%0b",
                 bus.o_valid, bus.o_ready, exp_q.size() != 0, exp_q.size() == 0);
      end
      if (bus.o_valid && exp_q.size() != 0) begin
        act = {bus.o_reg, bus.o_base, bus.o_offset, bus.o_load, bus.o_user,
               bus.o_nop, bus.o_wb, bus.o_last};
        cmp = act;
        if (exp_q[0].nop) cmp.rg = exp_q[0].rg;
        checks++;
        if (cmp !== exp_q[0]) begin
          errors++;
          $display("FAIL uop: got reg=%0d base=%0d off=%h ld=%0b us=%0b nop=%0b wb=%0b last=%0b, required reg=%0d base=%0d off=%h ld=%0b us=%0b nop=%0b wb=%0b last=%0b",
                   act.rg, act.base, act.off, act.load, act.user, act.nop, act.wb, act.last,
                   exp_q[0].rg, exp_q[0].base, exp_q[0].off, exp_q[0].load, exp_q[0].user,
                   exp_q[0].nop, exp_q[0].wb, exp_q[0].last);
        end
        if (bus.i_flush) begin
          exp_q.delete();
        end else if (bus.i_ready) begin
          $display("uop reg=%0d base=%0d off=%0d ld=%0b nop=%0b wb=%0b last=%0b",
                   act.rg, act.base, $signed(act.off), act.load, act.nop, act.wb, act.last);
          obs_q.push_back(act);
          void'(exp_q.pop_front());
        end
      end else if (bus.i_flush) begin
        exp_q.delete();
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic issue(input logic [31:0] ins);
    int cyc = 0;
    while (!bus.o_ready && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("issue_ready", 32'(bus.o_ready), 32'd1);
    obs_q.delete();
    bus.i_valid        = 1'b1;
    bus.i_instr        = ins;
    bus.i_total_offset = 12'(4 * popcnt(ins[15:0]));
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    push_model(ins);
  endtask

  task automatic wait_done(input string name);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s timeout: %0d uops left, required 0", name, exp_q.size());
    end
  endtask

  function automatic logic [31:0] out_vec();
    return 32'({bus.o_valid, bus.o_reg, bus.o_base, bus.o_offset, bus.o_load,
                bus.o_user, bus.o_nop, bus.o_wb, bus.o_last});
  endfunction

  initial begin
    op_t o;
    int  cyc;
    rst_n              = 1'b0;
    bus.i_valid        = 1'b0;
    bus.i_instr        = '0;
    bus.i_total_offset = '0;
    bus.i_flush        = 1'b0;
    bus.i_ready        = 1'b1;
    #2;
    chk("rst_outputs", out_vec(), 32'd0);
    chk("rst_ready", 32'(bus.o_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // IA, Rn=2, W=1, R0..R3
    issue(mk(0, 1, 0, 1, 1, 4'd2, 16'h000F));
    wait_done("ia");
    chk("ia_count", 32'(obs_q.size()), WB_BUILD ? 32'd5 : 32'd4);
    o = obs_at(0); chk("ia_off0", 32'(o.off), 32'h0);
    o = obs_at(3); chk("ia_r3", 32'({o.rg, o.off}), 32'({4'd3, 13'd12}));
    if (WB_BUILD) begin
      o = obs_at(4);
      chk("ia_wb", 32'({o.wb, o.last, o.rg, o.off}), 32'({2'b11, 4'd2, 13'd16}));
    end else begin
      o = obs_at(3); chk("ia_last", 32'(o.last), 32'd1);
    end

    // DB, W=0, R0 and R15
    issue(mk(1, 0, 0, 0, 0, 4'd5, 16'h8001));
    wait_done("db");
    chk("db_count", 32'(obs_q.size()), 32'd2);
    o = obs_at(0); chk("db_r0", 32'({o.rg, o.off, o.last}), 32'({4'd0, 13'h1FF8, 1'b0}));
    o = obs_at(1); chk("db_r15", 32'({o.rg, o.off, o.last}), 32'({4'd15, 13'h1FFC, 1'b1}));

    // IB single register with downstream stalled for 3 cycles
    bus.i_ready = 1'b0;
    issue(mk(1, 1, 0, 0, 1, 4'd1, 16'h0010));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ib_stall", 32'({bus.o_valid, bus.o_reg, bus.o_offset}), 32'({1'b1, 4'd4, 13'd4}));
      @(posedge clk); #1;
    end
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    chk("ib_ready_after", 32'({bus.o_ready, bus.o_valid}), 32'b10);
    chk("ib_count", 32'(obs_q.size()), 32'd1);

    // DA, full list, W=1
    issue(mk(0, 0, 0, 1, 1, 4'd3, 16'hFFFF));
    wait_done("da");
    chk("da_count", 32'(obs_q.size()), WB_BUILD ? 32'd17 : 32'd16);
    o = obs_at(0);  chk("da_first", 32'({o.rg, o.off}), 32'({4'd0, 13'h1FC4}));
    o = obs_at(15); chk("da_r15", 32'({o.rg, o.off}), 32'({4'd15, 13'd0}));
    if (WB_BUILD) begin
      o = obs_at(16); chk("da_wb", 32'({o.wb, o.off}), 32'({1'b1, 13'h1FC0}));
    end

    // Empty list, IB with W=1: single NOP, no writeback
    issue(mk(1, 1, 0, 1, 0, 4'd7, 16'h0000));
    wait_done("empty");
    chk("empty_count", 32'(obs_q.size()), 32'd1);
    o = obs_at(0); chk("empty_op", 32'({o.nop, o.last, o.wb, o.off}), 32'({3'b110, 13'd0}));

    // Flush while the third of five registers is presented
    issue(mk(0, 1, 0, 0, 1, 4'd6, 16'h001F));
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.i_flush = 1'b1;
    @(posedge clk); #1;
    bus.i_flush = 1'b0;
    chk("flush_state", 32'({bus.o_valid, bus.o_ready}), 32'b01);
    chk("flush_count", 32'(obs_q.size()), 32'd2);
    o = obs_at(1); chk("flush_r1", 32'({o.rg, o.off}), 32'({4'd1, 13'd4}));

    // Asynchronous reset during the final micro-op (WB when enabled)
    issue(mk(0, 1, 0, 1, 1, 4'd9, 16'h0003));
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(bus.o_valid && bus.o_last) && cyc < 20);
    chk("rst_mid_reached", 32'(bus.o_valid && bus.o_last), 32'd1);
    chk("rst_mid_kind", 32'(bus.o_wb), 32'(WB_BUILD));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", out_vec(), 32'd0);
    chk("rst_mid_ready", 32'(bus.o_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Recovery after reset
    issue(mk(0, 1, 0, 0, 1, 4'd4, 16'h0100));
    wait_done("recover");
    o = obs_at(0); chk("recover_op", 32'({o.rg, o.off, o.last}), 32'({4'd8, 13'd0, 1'b1}));

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
